mul_share_arbiter: RTL and testbench

- Shares the single-stage pipelined multiplier (1-cycle latency, always ready) between NUM_REQ requesters, e.g. the integer issue port and the NRNG post-processing unit.
- Arbitrates round-robin, forwards only legal multiply ops, and tracks the one in-flight operation.
- Steers each result into a per-requester one-entry response buffer, so requesters may apply back-pressure even though the multiplier cannot.

---
 rtl/mul_share_arbiter_pkg.sv | 22 ++
 rtl/mul_share_arbiter_if.sv | 30 +++
 rtl/mul_rr_pick.sv | 31 +++
 rtl/mul_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_mul_share_arbiter.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_arbiter_pkg.sv
// Shared types for the multiplier-sharing arbiter: operator encoding, widths and the
// buffered response record.
package mul_share_arbiter_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [3:0] {
        ADD, SUB, ANDL, ORL, XORL, SLL, SRL, SRA,
        MUL, MULH, MULHU, MULHSU, MULW, DIV, REM
    } fu_op;

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } mul_rsp_t;

    function automatic logic is_mul_op(fu_op op);
        return op inside {MUL, MULH, MULHU, MULHSU, MULW};
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester-facing bus of the multiplier-sharing arbiter: per-requester issue handshake,
// buffered response handshake and the illegal-op pulse.
interface mul_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    import mul_share_arbiter_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    fu_op                     req_op       [NUM_REQ];
    logic [XLEN-1:0]          req_a        [NUM_REQ];
    logic [XLEN-1:0]          req_b        [NUM_REQ];
    logic [TRANS_ID_BITS-1:0] req_trans_id [NUM_REQ];
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [XLEN-1:0]          rsp_result   [NUM_REQ];
    logic [TRANS_ID_BITS-1:0] rsp_trans_id [NUM_REQ];
    logic [NUM_REQ-1:0]       illegal;

    modport master (
        output req_valid, req_op, req_a, req_b, req_trans_id, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_trans_id, illegal
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_trans_id, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_trans_id, illegal
    );

endinterface

// File: rtl/mul_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after the pointer,
// wrapping modulo NUM_REQ.
module mul_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0]   rr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    int unsigned cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(rr_i) + off) % NUM_REQ;
            if (!valid_o && eligible_i[IDX_W'(cand)]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(cand);
                gnt_o   = NUM_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one 1-cycle pipelined multiplier between NUM_REQ requesters with round-robin
// arbitration, single in-flight tracking and a one-entry response buffer per requester.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    mul_share_arbiter_if.slave       bus,
    output logic                     mul_valid_o,
    output fu_op                     mul_op_o,
    output logic [XLEN-1:0]          mul_a_o,
    output logic [XLEN-1:0]          mul_b_o,
    output logic [TRANS_ID_BITS-1:0] mul_trans_id_o,
    input  logic                     mul_ready_i,
    input  logic                     mul_valid_i,
    input  logic [XLEN-1:0]          mul_result_i,
    input  logic [TRANS_ID_BITS-1:0] mul_trans_id_i
);

    logic [IDX_W-1:0]         rr_q, rr_d;
    logic                     inflight_q, inflight_d;
    logic [IDX_W-1:0]         inflight_idx_q, inflight_idx_d;
    logic [TRANS_ID_BITS-1:0] inflight_tid_q, inflight_tid_d;
    logic [NUM_REQ-1:0]       buf_v_q, buf_v_d;
    mul_rsp_t                 buf_q [NUM_REQ];
    mul_rsp_t                 buf_d [NUM_REQ];

    logic [NUM_REQ-1:0] base, eligible, take_illegal, gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               ret_ok, fill_en;

    // A draining buffer counts as free; illegal ops are swallowed without using the grant.
    always_comb begin
        base         = '0;
        eligible     = '0;
        take_illegal = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            base[i] = bus.req_valid[i] && mul_ready_i && !flush_i
                      && !(inflight_q && (inflight_idx_q == IDX_W'(i)))
                      && !(buf_v_q[i] && !bus.rsp_ready[i]);
            eligible[i]     = base[i] && is_mul_op(bus.req_op[i]);
            take_illegal[i] = base[i] && !is_mul_op(bus.req_op[i]);
        end
    end

    mul_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .eligible_i (eligible),
        .rr_i       (rr_q),
        .gnt_o      (gnt),
        .idx_o      (gnt_idx),
        .valid_o    (gnt_valid)
    );

    assign bus.req_ready = gnt | take_illegal;
    assign bus.illegal   = take_illegal;
    assign bus.rsp_valid = buf_v_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : gen_rsp
        assign bus.rsp_result[g]   = buf_q[g].result;
        assign bus.rsp_trans_id[g] = buf_q[g].trans_id;
    end

    always_comb begin
        mul_valid_o    = gnt_valid;
        mul_op_o       = ADD;
        mul_a_o        = '0;
        mul_b_o        = '0;
        mul_trans_id_o = '0;
        if (gnt_valid) begin
            mul_op_o       = bus.req_op[gnt_idx];
            mul_a_o        = bus.req_a[gnt_idx];
            mul_b_o        = bus.req_b[gnt_idx];
            mul_trans_id_o = bus.req_trans_id[gnt_idx];
        end
    end

    assign ret_ok  = mul_valid_i && inflight_q && (mul_trans_id_i == inflight_tid_q);
    assign fill_en = ret_ok && !flush_i;

    always_comb begin
        rr_d           = rr_q;
        inflight_d     = inflight_q;
        inflight_idx_d = inflight_idx_q;
        inflight_tid_d = inflight_tid_q;
        buf_v_d        = buf_v_q & ~bus.rsp_ready;
        buf_d          = buf_q;

        if (mul_valid_i && inflight_q) begin
            inflight_d = 1'b0;
        end
        // Fill after drain so a same-cycle fill keeps the buffer valid.
        if (fill_en) begin
            buf_v_d[inflight_idx_q] = 1'b1;
            buf_d[inflight_idx_q]   = '{result: mul_result_i, trans_id: mul_trans_id_i};
        end
        if (gnt_valid) begin
            rr_d           = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            inflight_d     = 1'b1;
            inflight_idx_d = gnt_idx;
            inflight_tid_d = bus.req_trans_id[gnt_idx];
        end
        if (flush_i) begin
            inflight_d = 1'b0;
            buf_v_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q           <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            inflight_tid_q <= '0;
            buf_v_q        <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            rr_q           <= rr_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            inflight_tid_q <= inflight_tid_d;
            buf_v_q        <= buf_v_d;
            buf_q          <= buf_d;
        end
    end

    // Stray or mistagged multiplier results must never reach a response buffer.
    a_stray_dropped: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mul_valid_i && !ret_ok) |-> !fill_en);

    a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt));

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter with a 1-cycle multiplier model and a
// per-requester response scoreboard.
module tb_mul_share_arbiter;
    import mul_share_arbiter_pkg::*;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned IDX_W   = 1;

    logic clk_i   = 1'b0;
    logic rst_ni  = 1'b1;
    logic flush_i = 1'b0;

    logic                     mul_valid_o;
    fu_op                     mul_op_o;
    logic [XLEN-1:0]          mul_a_o, mul_b_o;
    logic [TRANS_ID_BITS-1:0] mul_trans_id_o;
    logic                     mul_ready_i    = 1'b1;
    logic                     mul_valid_i    = 1'b0;
    logic [XLEN-1:0]          mul_result_i   = '0;
    logic [TRANS_ID_BITS-1:0] mul_trans_id_i = '0;
    logic                     inject         = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN+TRANS_ID_BITS-1:0] exp0_q[$];
    logic [XLEN+TRANS_ID_BITS-1:0] exp1_q[$];

    logic [1:0]  s_ready, s_rsp_valid, s_illegal;
    logic        s_mul_valid;
    logic [31:0] s_mul_a, s_res0, s_res1;
    logic [2:0]  s_tid0, s_mul_tid;

    mul_share_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    mul_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .bus            (bus),
        .mul_valid_o    (mul_valid_o),
        .mul_op_o       (mul_op_o),
        .mul_a_o        (mul_a_o),
        .mul_b_o        (mul_b_o),
        .mul_trans_id_o (mul_trans_id_o),
        .mul_ready_i    (mul_ready_i),
        .mul_valid_i    (mul_valid_i),
        .mul_result_i   (mul_result_i),
        .mul_trans_id_i (mul_trans_id_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_mul(fu_op op, logic [31:0] a, logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MULH:    begin p = sa * sb; return p[63:32]; end
            MULHU:   begin p = ua * ub; return p[63:32]; end
            MULHSU:  begin p = sa * ub; return p[63:32]; end
            default: begin p = ua * ub; return p[31:0];  end
        endcase
    endfunction

    function automatic logic tb_legal(fu_op op);
        return op inside {MUL, MULH, MULHU, MULHSU, MULW};
    endfunction

    // Multiplier model: one cycle latency, optional stray-return injection.
    always @(posedge clk_i) begin
        mul_valid_i    <= mul_valid_o | inject;
        mul_trans_id_i <= inject ? 3'd0 : mul_trans_id_o;
        mul_result_i   <= ref_mul(mul_op_o, mul_a_o, mul_b_o);
    end

    task automatic set_req(int unsigned i, logic v, fu_op op, logic [31:0] a, logic [31:0] b,
                           logic [2:0] tid);
        bus.req_valid[i]    = v;
        bus.req_op[i]       = op;
        bus.req_a[i]        = a;
        bus.req_b[i]        = b;
        bus.req_trans_id[i] = tid;
    endtask

    task automatic idle_inputs();
        flush_i       = 1'b0;
        inject        = 1'b0;
        bus.rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) set_req(i, 1'b0, ADD, '0, '0, '0);
    endtask

    // Sample this cycle at the falling edge, run the scoreboard, advance past the next edge.
    task automatic cyc();
        logic [XLEN+TRANS_ID_BITS-1:0] got, exp;
        @(negedge clk_i);
        s_ready     = bus.req_ready;
        s_rsp_valid = bus.rsp_valid;
        s_illegal   = bus.illegal;
        s_mul_valid = mul_valid_o;
        s_mul_a     = mul_a_o;
        s_mul_tid   = mul_trans_id_o;
        s_res0      = bus.rsp_result[0];
        s_res1      = bus.rsp_result[1];
        s_tid0      = bus.rsp_trans_id[0];
        for (int i = 0; i < 2; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i] && tb_legal(bus.req_op[i])) begin
                exp = {ref_mul(bus.req_op[i], bus.req_a[i], bus.req_b[i]), bus.req_trans_id[i]};
                if (i == 0) exp0_q.push_back(exp);
                else        exp1_q.push_back(exp);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
                got = {bus.rsp_result[i], bus.rsp_trans_id[i]};
                n_checks++;
                if ((i == 0 ? exp0_q.size() : exp1_q.size()) == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_unexpected_rsp%0d: got %h required none", i, got);
                end else begin
                    exp = (i == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL scoreboard_rsp%0d: got %h required %h", i, got, exp);
                    end
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_ni = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.illegal, mul_valid_o} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0",
                     {bus.req_ready, bus.rsp_valid, bus.illegal, mul_valid_o});
        end
        n_checks++;
        if ({mul_a_o, mul_b_o, bus.rsp_result[0], bus.rsp_result[1]} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h required 0", mul_a_o, bus.rsp_result[0]);
        end
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        cyc();
        n_checks++;
        if ({s_rsp_valid, s_mul_valid} !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b required 000", {s_rsp_valid, s_mul_valid});
        end
    endtask

    task automatic test_single();
        logic [31:0] a;
        logic [2:0]  tid;
        apply_reset();
        set_req(0, 1'b1, MUL, 32'd3, 32'd5, 3'd1);
        cyc();
        n_checks++;
        if ({s_ready, s_mul_valid, s_mul_a, s_mul_tid} !== {2'b01, 1'b1, 32'd3, 3'd1}) begin
            n_fail++;
            $display("FAIL single_issue: got rdy=%b mv=%b a=%0d tid=%0d required 01/1/3/1",
                     s_ready, s_mul_valid, s_mul_a, s_mul_tid);
        end
        set_req(0, 1'b0, ADD, '0, '0, '0);
        cyc();
        n_checks++;
        if (s_rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL single_early_rsp: got %b required 00", s_rsp_valid);
        end
        cyc();
        n_checks++;
        if ({s_rsp_valid[0], s_res0, s_tid0} !== {1'b1, 32'd15, 3'd1}) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%b res=%0d tid=%0d required 1/15/1",
                     s_rsp_valid[0], s_res0, s_tid0);
        end
        a   = 32'd10;
        tid = 3'd2;
        for (int c = 0; c < 6; c++) begin
            set_req(0, 1'b1, MUL, a, 32'd7, tid);
            cyc();
            n_checks++;
            if (s_ready[0] !== ((c % 2) == 0)) begin
                n_fail++;
                $display("FAIL b2b_ready c%0d: got %b required %b", c, s_ready[0], (c % 2) == 0);
            end
            if (s_ready[0]) begin
                a++;
                tid++;
            end
        end
        idle_inputs();
        repeat (3) cyc();
    endtask

    task automatic test_contention();
        logic [31:0] a0;
        logic [2:0]  t0, t1;
        apply_reset();
        a0 = 32'd1;
        t0 = 3'd0;
        t1 = 3'd4;
        for (int c = 0; c < 8; c++) begin
            set_req(0, 1'b1, MUL, a0, a0 + 32'd1, t0);
            set_req(1, 1'b1, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t1);
            cyc();
            n_checks++;
            if ({s_ready, s_mul_valid} !== {((c % 2) == 0) ? 2'b01 : 2'b10, 1'b1}) begin
                n_fail++;
                $display("FAIL contention_grant c%0d: got rdy=%b mv=%b", c, s_ready, s_mul_valid);
            end
            if (c == 3) begin
                n_checks++;
                if ({s_rsp_valid[1], s_res1} !== {1'b1, 32'hFFFF_FFFE}) begin
                    n_fail++;
                    $display("FAIL contention_mulhu: got v=%b res=%h required 1/fffffffe",
                             s_rsp_valid[1], s_res1);
                end
            end
            if (s_ready[0]) begin
                a0++;
                t0++;
            end
            if (s_ready[1]) t1++;
        end
        idle_inputs();
        repeat (3) cyc();
    endtask

    task automatic test_backpressure();
        int          g1;
        logic [31:0] b1;
        apply_reset();
        bus.rsp_ready = 2'b10;
        set_req(0, 1'b1, MUL, 32'd3, 32'd5, 3'd2);
        cyc();
        n_checks++;
        if (s_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_first_grant: got %b required 01", s_ready);
        end
        b1 = 32'd2;
        set_req(0, 1'b1, MUL, 32'd7, 32'd6, 3'd3);
        set_req(1, 1'b1, MUL, 32'd2, b1, 3'd0);
        cyc();
        g1 = 0;
        for (int c = 2; c <= 6; c++) begin
            cyc();
            n_checks++;
            if ({s_ready[0], s_rsp_valid[0], s_res0} !== {1'b0, 1'b1, 32'd15}) begin
                n_fail++;
                $display("FAIL bp_hold c%0d: got rdy0=%b v0=%b res0=%0d required 0/1/15",
                         c, s_ready[0], s_rsp_valid[0], s_res0);
            end
            if (s_ready[1]) begin
                g1++;
                b1++;
                set_req(1, 1'b1, MUL, 32'd2, b1, 3'(c));
            end
        end
        n_checks++;
        if (g1 != 2) begin
            n_fail++;
            $display("FAIL bp_req1_served: got %0d grants required 2", g1);
        end
        bus.rsp_ready[0] = 1'b1;
        cyc();
        n_checks++;
        if (s_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_resume: got %b required 01", s_ready);
        end
        idle_inputs();
        repeat (3) cyc();
    endtask

    task automatic test_illegal();
        set_req(1, 1'b1, ADD, 32'd1, 32'd2, 3'd6);
        cyc();
        n_checks++;
        if ({s_ready, s_illegal, s_mul_valid} !== {2'b10, 2'b10, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_take: got rdy=%b ill=%b mv=%b required 10/10/0",
                     s_ready, s_illegal, s_mul_valid);
        end
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_checks++;
            if ({s_rsp_valid[1], s_illegal} !== 3'b000) begin
                n_fail++;
                $display("FAIL illegal_after c%0d: got v1=%b ill=%b required 0/00",
                         c, s_rsp_valid[1], s_illegal);
            end
        end
        set_req(0, 1'b1, MUL, 32'd9, 32'd9, 3'd1);
        set_req(1, 1'b1, SUB, 32'd4, 32'd4, 3'd2);
        cyc();
        n_checks++;
        if ({s_ready, s_illegal, s_mul_valid, s_mul_a} !== {2'b11, 2'b10, 1'b1, 32'd9}) begin
            n_fail++;
            $display("FAIL illegal_with_grant: got rdy=%b ill=%b mv=%b a=%0d required 11/10/1/9",
                     s_ready, s_illegal, s_mul_valid, s_mul_a);
        end
        idle_inputs();
        repeat (3) cyc();
    endtask

    task automatic test_flush();
        bus.rsp_ready = 2'b10;
        set_req(0, 1'b1, MUL, 32'd2, 32'd9, 3'd1);
        cyc();
        set_req(0, 1'b0, ADD, '0, '0, '0);
        repeat (2) cyc();
        n_checks++;
        if (s_rsp_valid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_prefill: got %b required 1", s_rsp_valid[0]);
        end
        set_req(1, 1'b1, MUL, 32'd6, 32'd7, 3'd2);
        cyc();
        n_checks++;
        if (s_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_grant: got %b required 10", s_ready);
        end
        set_req(1, 1'b0, ADD, '0, '0, '0);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
        n_checks++;
        if (s_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_no_ready: got %b required 00", s_ready);
        end
        for (int c = 0; c < 2; c++) begin
            cyc();
            n_checks++;
            if (s_rsp_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL flush_cleared c%0d: got %b required 00", c, s_rsp_valid);
            end
        end
        bus.rsp_ready = 2'b11;
        set_req(0, 1'b1, MUL, 32'd5, 32'd5, 3'd4);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        n_checks++;
        if ({s_ready, s_mul_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_blocks_grant: got rdy=%b mv=%b required 00/0", s_ready, s_mul_valid);
        end
        cyc();
        n_checks++;
        if (s_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_next_grant: got %b required 01", s_ready);
        end
        idle_inputs();
        repeat (2) cyc();
        n_checks++;
        if ({s_rsp_valid[0], s_res0} !== {1'b1, 32'd25}) begin
            n_fail++;
            $display("FAIL flush_next_rsp: got v=%b res=%0d required 1/25", s_rsp_valid[0], s_res0);
        end
        repeat (2) cyc();
    endtask

    task automatic test_reset_mid();
        bus.rsp_ready = 2'b10;
        set_req(0, 1'b1, MUL, 32'd3, 32'd5, 3'd1);
        cyc();
        set_req(0, 1'b0, ADD, '0, '0, '0);
        repeat (2) cyc();
        set_req(1, 1'b1, MUL, 32'd4, 32'd4, 3'd2);
        cyc();
        set_req(1, 1'b0, ADD, '0, '0, '0);
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready, bus.illegal, mul_valid_o, bus.rsp_result[0]} !== 39'd0)
        begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got v=%b rdy=%b mv=%b res0=%0d required 0",
                     bus.rsp_valid, bus.req_ready, mul_valid_o, bus.rsp_result[0]);
        end
        exp0_q.delete();
        exp1_q.delete();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        bus.rsp_ready = 2'b11;
        inject = 1'b1;
        cyc();
        inject = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cyc();
            n_checks++;
            if (s_rsp_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_stray c%0d: got %b required 00", c, s_rsp_valid);
            end
        end
        set_req(0, 1'b1, MUL, 32'd8, 32'd8, 3'd0);
        set_req(1, 1'b1, MUL, 32'd3, 32'd3, 3'd1);
        cyc();
        n_checks++;
        if (s_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b required 01", s_ready);
        end
        idle_inputs();
        repeat (4) cyc();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_mid();
        n_checks++;
        if (exp0_q.size() + exp1_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: got %0d pending required 0",
                     exp0_q.size() + exp1_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
